// File: rtl/flag_table_scanner.sv
// flag_table_scanner
//   Drains a read-clear flag table. While the table reports a non-zero aggregate,
//   it walks the table indices round-robin and issues one read-clear request per
//   index. Every non-zero result is forwarded as an (index, value) event on a
//   valid/ready stream. A read is destructive, so an event is held until the
//   consumer accepts it and is never dropped.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ST_IDLE | no scan in progress; r_idx holds the next index to visit
//   ST_REQ  | single-cycle read-clear request for r_idx
//   ST_WAIT | waiting for rdack (bounded by TIMEOUT_CYCLES)
//   ST_PUSH | holding a non-zero event until the consumer accepts it
//
// Ports
//   clk, rstn                        clock, synchronous active-low reset
//   i_enable                         scan enable (level)
//   i_tbl_init_done, i_tbl_non_zero  table status
//   o_rdreq_valid, o_rdreq_index     read-clear request to the table
//   i_rdack_valid, i_rdack_value     read result (1-cycle pulse)
//   o_out_valid/i_out_ready          event stream handshake
//   o_out_index, o_out_value         event payload (value never 0)
//   o_err_timeout                    1-cycle pulse when an rdack never arrived
//   o_event_count                    accepted events, saturating
module flag_table_scanner #(
    parameter int INDEX_WIDTH    = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_enable,
    input  logic                   i_tbl_init_done,
    input  logic                   i_tbl_non_zero,
    output logic                   o_rdreq_valid,
    output logic [INDEX_WIDTH-1:0] o_rdreq_index,
    input  logic                   i_rdack_valid,
    input  logic [DATA_WIDTH-1:0]  i_rdack_value,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [INDEX_WIDTH-1:0] o_out_index,
    output logic [DATA_WIDTH-1:0]  o_out_value,
    output logic                   o_err_timeout,
    output logic [31:0]            o_event_count
);

    localparam int                     TCNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0]      TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_MAX  = {INDEX_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PUSH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [TCNT_W-1:0]      r_tcnt;
    logic [INDEX_WIDTH-1:0] r_out_index;
    logic [DATA_WIDTH-1:0]  r_out_value;
    logic [31:0]            r_event_count;

    logic w_advance;
    logic w_capture;
    logic w_timeout;
    logic w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_tbl_init_done && i_tbl_non_zero) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // An rdack in the expiry cycle takes priority over the timeout.
                if (i_rdack_valid) begin
                    if (i_rdack_value != '0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_PUSH;
                    end else begin
                        w_advance = 1'b1;
                    end
                end else if (r_tcnt == TCNT_MAX) begin
                    w_timeout = 1'b1;
                    w_advance = 1'b1;
                end
            end
            ST_PUSH: begin
                if (i_out_ready) begin
                    w_accept  = 1'b1;
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Resolving an index re-evaluates the scan condition; init_done is
        // only a gate for leaving idle.
        if (w_advance) begin
            w_state_nxt = (i_enable && i_tbl_non_zero) ? ST_REQ : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_tcnt        <= '0;
            r_out_index   <= '0;
            r_out_value   <= '0;
            r_event_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_REQ) begin
                r_tcnt <= '0;
            end else if (r_state == ST_WAIT && !i_rdack_valid) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_capture) begin
                r_out_index <= r_idx;
                r_out_value <= i_rdack_value;
            end
            if (w_accept && (r_event_count != 32'hFFFF_FFFF)) begin
                r_event_count <= r_event_count + 32'd1;
            end
            if (w_advance) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign o_rdreq_valid = (r_state == ST_REQ);
    assign o_rdreq_index = r_idx;
    assign o_out_valid   = (r_state == ST_PUSH);
    assign o_out_index   = r_out_index;
    assign o_out_value   = r_out_value;
    assign o_err_timeout = w_timeout;
    assign o_event_count = r_event_count;

endmodule
